// File: rtl/counter_pkg.sv
// Shared constants for the counter library: step direction and limit behaviour.
package counter_pkg;

   // Direction of an enabled step, encoded to match the mode input pin.
   typedef enum logic {
      CNT_DN = 1'b0,
      CNT_UP = 1'b1
   } dir_e;

   // Limit behaviour: wrap around to the opposite limit, or hold at the limit.
   localparam int CNT_WRAP = 0;
   localparam int CNT_SAT  = 1;

endpackage

// File: rtl/counter_next_val.sv
// Combinational next-value logic for a bounded up/down counter.
// Given the present count and the direction, produces the count after one
// enabled step and flags whether that step hit a limit.
module CounterNextVal
   import counter_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
   parameter int               SATURATE = CNT_WRAP
) (
   input  logic [WIDTH-1:0] count,
   input  dir_e             dir,
   output logic [WIDTH-1:0] nextCount,
   output logic             boundary
);

   // One step in the requested direction; at a limit either wrap to the
   // opposite limit or stay put, and report the limit hit either way.
   always_comb begin
      nextCount = count;
      boundary  = 1'b0;
      if (dir == CNT_UP) begin
         if (count == MAX_VAL) begin
            boundary  = 1'b1;
            nextCount = (SATURATE == CNT_SAT) ? MAX_VAL : '0;
         end else begin
            nextCount = count + 1'b1;
         end
      end else begin
         if (count == '0) begin
            boundary  = 1'b1;
            nextCount = (SATURATE == CNT_SAT) ? '0 : MAX_VAL;
         end else begin
            nextCount = count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with enable, synchronous clamped load,
// wrap/saturate limit behaviour and a registered terminal-count pulse.
// Legal counts are 0..MAX_VAL; the count register never leaves that range.
module updown_counter_param
   import counter_pkg::*;
#(
   parameter int          WIDTH    = 8,
   parameter int unsigned MAX_VAL  = 2**WIDTH-1,
   parameter int          SATURATE = CNT_WRAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             at_max,
   output logic             at_min
);

   // Upper limit reduced to the counter width so every comparison stays at WIDTH bits.
   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] stepCount;
   logic             stepBoundary;
   logic [WIDTH-1:0] loadClamped;

   CounterNextVal #(
      .WIDTH    (WIDTH),
      .MAX_VAL  (MAX_C),
      .SATURATE (SATURATE)
   ) uNextVal (
      .count     (count),
      .dir       (dir_e'(mode)),
      .nextCount (stepCount),
      .boundary  (stepBoundary)
   );

   // Loaded values above the limit are pulled down to the limit so an
   // out-of-range load can never put the counter in an illegal state.
   always_comb begin
      loadClamped = load_val;
      if (load_val > MAX_C) begin
         loadClamped = MAX_C;
      end
   end

   // State update with priority reset > load > enabled step > hold; tc only
   // reflects a limit hit on this edge's enabled step.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         tc    <= 1'b0;
      end else if (load) begin
         count <= loadClamped;
         tc    <= 1'b0;
      end else if (en) begin
         count <= stepCount;
         tc    <= stepBoundary;
      end else begin
         tc    <= 1'b0;
      end
   end

   assign at_max = (count == MAX_C);
   assign at_min = (count == '0);

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised up/down counter; successor to the fixed 8-bit up/down counter in the counter library.
- Generalised in width and modulus; adds count enable, synchronous parallel load, selectable wrap or saturate mode, and a registered terminal-count event pulse.
- Used as a general event/timer counter inside larger datapath and control blocks.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- MAX_VAL, 2**WIDTH-1, upper count limit; legal counts are 0..MAX_VAL; requires 1 <= MAX_VAL <= 2**WIDTH-1.
- SATURATE, 0, 0 = wrap at limits; 1 = hold at limits.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable; step taken only when high.
- mode  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- count  output  WIDTH  current count (registered).
- tc  output  1  registered one-cycle pulse: boundary crossing attempted on the previous enabled step.
- at_max  output  1  combinational, count == MAX_VAL.
- at_min  output  1  combinational, count == 0.

Behaviour:
- Priority per edge: rst > load > en > hold.
- Reset (rst=1 at edge): count=0, tc=0; hence at_min=1, at_max=0. Overrides load and en in the same cycle.
- Load: count <= min(load_val, MAX_VAL); out-of-range values clamp to MAX_VAL; tc <= 0; en ignored that cycle.
- Enabled up step: if count < MAX_VAL, then count+1, tc<=0; if count == MAX_VAL, then wrap to 0 (SATURATE=0) or hold MAX_VAL (SATURATE=1), tc<=1 in both cases.
- Enabled down step: if count > 0, then count-1, tc<=0; if count == 0, then wrap to MAX_VAL (SATURATE=0) or hold 0 (SATURATE=1), tc<=1.
- en=0, load=0: count holds, tc<=0. tc is never high on two consecutive cycles unless boundary steps are repeated; under saturation with en held at the limit, tc stays high every cycle.
- Latency: one clock from en/load/rst sample to count/tc update; at_max/at_min follow count with no added latency.
- Arithmetic: comparisons against MAX_VAL are done at WIDTH bits; no internal carry beyond WIDTH; count is never outside 0..MAX_VAL.
- mode may change on any cycle; the new direction applies to that edge's step.
- No initial blocks are relied on; state is defined only by reset.
- Unknown (X) on mode with en=1 is a bench error; the design is not required to handle it.

Decomposition:
- Shared package counter_pkg: direction constants CNT_DN=1'b0 and CNT_UP=1'b1; wrap/saturate mode constants.
- Optional combinational sub-module counter_next_val (count, mode, MAX_VAL, SATURATE to next value plus boundary flag) keeps the sequential shell trivial. A single-module implementation is also acceptable.

Test Plan:
- Reset: WIDTH=8, drive en=1 and load=1 with rst=1 -> count=0, tc=0, at_min=1 after edge; release rst and 3 up steps -> count=3.
- Wrap up: MAX_VAL=9, SATURATE=0, load 8, up 2 steps -> count 9 then 0, tc=1 only in the cycle after the 9->0 edge, at_max=1 while count=9.
- Wrap down: MAX_VAL=9, count=0, down 1 step -> count=9, tc=1; next step -> count 8, tc=0.
- Saturate: SATURATE=1, MAX_VAL=255, load 254, up 3 steps -> count 255,255,255 and tc 0,1,1; down step -> count 254, tc=0.
- Load priority/clamp: MAX_VAL=9, en=1, mode=1, load=1, load_val=200 -> count=9 (clamped, no increment), tc=0.
- Hold/direction change: en=0 for 5 cycles -> count unchanged; alternate mode each cycle with en=1 from count=5 -> 6,5,6,5.
